// File: rtl/shared_down_timer_arbiter.sv
// shared_down_timer_arbiter: round-robin sharing of one n-bit down-counter among N_REQ requesters,
// pulsing done to the owner when its loaded delay expires.
module shared_down_timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int n     = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*n-1:0] load_val,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic [n-1:0]       count,
    output logic               busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state;
    logic [IW-1:0]  last;
    logic [IW-1:0]  win;
    logic           found;
    logic [n-1:0]   slice [N_REQ];
    genvar i;
    generate
        for (i = 0; i < N_REQ; i++) begin : g_slice
            assign slice[i] = load_val[i*n +: n];
        end
    endgenerate
    // search starts just after the previous owner, so it gets lowest priority
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[IW'((int'(last) + k) % N_REQ)]) begin
                found = 1'b1;
                win   = IW'((int'(last) + k) % N_REQ);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            count <= '0;
            last  <= IW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: if (found) begin
                    state <= RUN;
                    grant <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    count <= slice[win];
                    last  <= win;
                end
                RUN: if (!req[last]) begin
                    state <= IDLE;
                    grant <= '0;
                end else if (count == '0) begin
                    state <= DONE;
                    done  <= grant;
                end else begin
                    count <= count - 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    done  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_shared_down_timer_arbiter.sv
// tb_shared_down_timer_arbiter: directed checks of arbitration order, timing, abort, boundary loads and reset.
module tb_shared_down_timer_arbiter;
    localparam int NR = 4;
    localparam int W  = 7;
    logic          clk = 1'b0;
    logic          reset_n;
    logic [NR-1:0] req;
    logic [NR*W-1:0] load_val;
    logic [NR-1:0] grant;
    logic [NR-1:0] done;
    logic [W-1:0]  count;
    logic          busy;
    int nerr = 0;
    int nchk = 0;

    shared_down_timer_arbiter #(.N_REQ(NR), .n(W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .load_val(load_val),
        .grant(grant), .done(done), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int c;
        int bad;
        int seen;
        int loads [4];
        loads = '{2, 3, 4, 5};
        reset_n  = 1'b0;
        req      = '0;
        load_val = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);

        // single request, load 5
        reset_n = 1'b1;
        req = 4'b0001;
        load_val[0*W +: W] = 7'd5;
        @(negedge clk);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_busy", busy, 1);
        chk("t1_load", count, 5);
        bad = 0;
        for (int k = 4; k >= 0; k--) begin
            @(negedge clk);
            if (count !== W'(k) || done !== 4'b0000) bad++;
        end
        chk("t1_countdown", bad, 0);
        @(negedge clk);
        chk("t1_done", done, 4'b0001);
        chk("t1_grant_held", grant, 4'b0001);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_done_clear", done, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_grant", grant, 0);

        // all four requesting, fresh reset so requester 0 leads
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        req = 4'b1111;
        for (int j = 0; j < NR; j++) load_val[j*W +: W] = W'(loads[j]);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("rr_grant", grant, 32'd1 << (t % NR));
            chk("rr_load", count, loads[t % NR]);
            c = 0;
            while (done === 4'b0000 && c < 300) begin
                @(negedge clk);
                c++;
            end
            chk("rr_latency", c, loads[t % NR] + 1);
            chk("rr_done", done, 32'd1 << (t % NR));
            @(negedge clk);
            chk("rr_idle_gap", grant, 0);
        end
        req = 4'b0000;

        // abort requester 2 at count 12
        req = 4'b0100;
        load_val[2*W +: W] = 7'd20;
        @(negedge clk);
        chk("ab_grant", grant, 4'b0100);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done !== 4'b0000) seen++;
        end
        chk("ab_count12", count, 12);
        req = 4'b0000;
        @(negedge clk);
        chk("ab_grant_clr", grant, 0);
        chk("ab_busy", busy, 0);
        chk("ab_hold", count, 12);
        repeat (3) begin
            @(negedge clk);
            if (done !== 4'b0000) seen++;
        end
        chk("ab_no_done", seen, 0);
        chk("ab_hold_late", count, 12);

        // load 0
        req = 4'b1000;
        load_val[3*W +: W] = 7'd0;
        @(negedge clk);
        chk("l0_grant", grant, 4'b1000);
        chk("l0_count", count, 0);
        @(negedge clk);
        chk("l0_done", done, 4'b1000);
        req = 4'b0000;
        @(negedge clk);
        chk("l0_idle", busy, 0);

        // load 127 with load_val[1] rewritten mid-run
        req = 4'b0010;
        load_val[1*W +: W] = 7'd127;
        @(negedge clk);
        chk("l127_grant", grant, 4'b0010);
        chk("l127_load", count, 127);
        c = 0;
        bad = 0;
        while (done === 4'b0000 && c < 300) begin
            @(negedge clk);
            c++;
            if (c == 10) load_val[1*W +: W] = 7'd3;
            if (count !== W'(c < 127 ? 127 - c : 0)) bad++;
        end
        chk("l127_latency", c, 128);
        chk("l127_done", done, 4'b0010);
        chk("l127_sequence", bad, 0);
        req = 4'b0000;
        @(negedge clk);
        chk("l127_idle", busy, 0);

        // reset in the middle of a run
        req = 4'b0001;
        load_val[0*W +: W] = 7'd10;
        @(negedge clk);
        chk("mr_grant", grant, 4'b0001);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mr_grant_rst", grant, 0);
        chk("mr_done_rst", done, 0);
        chk("mr_busy_rst", busy, 0);
        chk("mr_count_rst", count, 0);
        reset_n = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        chk("mr_winner", grant, 4'b0001);
        req = 4'b0000;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
